decode_writeback: RTL and testbench
===================================

# decode_writeback

Combined decode and write-back stage for the SEQ Y86-64 processor, sitting directly downstream of fetch. It derives the source and destination register IDs from the fetched `icode`, `rA`, `rB`, and reads `valA`/`valB` from a 15×64-bit register file. At the end of each committed cycle it writes `valE`/`valM` back into the register file. It also owns the processor status state machine, which blocks all further register writes once a halt or an error is reached.

## Interface
- `RSP_INIT`, default 64'h3F8: reset value of `%rsp` (register 4); all other registers reset to 0.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `icode`, `ifun` in 4 each: from fetch.
- `rA`, `rB` in 4 each: from fetch; 4'hF means no register.
- `instr_valid` in 1: high means the fetched instruction is legal.
- `imem_error` in 1: instruction-fetch address error.
- `dmem_error` in 1: data-memory error from the memory stage in the same cycle.
- `cnd` in 1: condition result from execute; gates the `cmovXX` write.
- `valE` in 64: ALU result from execute.
- `valM` in 64: load result from memory.
- `commit` in 1: end-of-instruction strobe; write-back and status update occur only at a rising edge with `commit`=1.
- `srcA`, `srcB`, `dstE`, `dstM` out 4: decoded register IDs.
- `valA`, `valB` out 64: register read data; 0 when the corresponding source is 4'hF.
- `stat` out 3: 1=AOK, 2=HLT, 3=ADR, 4=INS.
- `halted` out 1: high when `stat` is not AOK.
- `dbg_addr` in 4, `dbg_data` out 64: combinational debug read port; returns 0 for 4'hF.

## Operation
- **srcA**: `rA` for icode 2, 4, 6, A; 4 (RSP) for icode 9, B; else F.
- **srcB**: `rB` for icode 4, 5, 6; 4 for icode 8, 9, A, B; else F.
- **dstE**:
  - icode 2: `rB` if `cnd`, else F.
  - icode 3, 6: `rB`.
  - icode 8, 9, A, B: 4.
  - All others: F.
- **dstM**: `rA` for icode 5, B; else F.
- `ifun` is ignored except as passed through to legality, which is already folded into `instr_valid`.
- **Reads**: combinational from the current array contents; they show pre-write values in the same cycle.
- **Write-back** on a `commit` edge while `stat`=AOK and this cycle's next-status is AOK:
  - `R[dstE]` ← `valE`, then `R[dstM]` ← `valM`.
  - If `dstE`==`dstM`≠F, `valM` wins (`popq %rsp`).
  - Writes to F are dropped.
- **Status FSM** (state changes only on `commit`), in priority order:
  - AOK → ADR if `imem_error` or `dmem_error`.
  - AOK → INS if `!instr_valid`.
  - AOK → HLT if `icode`==0.
  - Otherwise stay in AOK.
  - HLT, ADR, INS are absorbing until `rst`.
  - The instruction that causes the transition performs no register write.
- `commit`=0: no state change and no writes; outputs continue to track the inputs combinationally.

## Timing
- Decode outputs and `valA`/`valB`: zero-cycle combinational latency from the inputs.
- Write-back values become visible on `valA`/`valB`/`dbg_data` in the cycle after the committing edge.
- `stat` updates on the committing edge; `halted` is a decode of registered `stat`.
- `rst` takes priority over `commit` at the same edge. After reset:
  - `stat`=1 (AOK), `halted`=0.
  - `R4`=`RSP_INIT`, all other registers 0.
- Reset asserted mid-program clears all registers and status at that edge regardless of other inputs.

## Structure
- **`y86_pkg`** (shared package) holds:
  - icode constants: `I_HALT`…`I_POPQ`.
  - `REG_RSP`=4, `REG_NONE`=4'hF.
  - Stat codes `S_AOK`/`S_HLT`/`S_ADR`/`S_INS`.
- **`regfile_15x64`** (sub-module):
  - Two combinational read ports plus the debug port.
  - Two write ports with M-over-E priority.
  - Synchronous reset using `RSP_INIT`.
- The decode logic and status FSM live in the top module.

## Test plan
- **Reset**: `rst` for 1 cycle → `stat`=1, `dbg_addr`=4 reads 64'h3F8, `dbg_addr`=0 reads 0.
- **irmovq (icode 3), rB=2, valE=64'h1234, commit** → next cycle `R2`=64'h1234, `dstE`=2, `srcA`=F, `valA`=0.
- **popq %rsp (icode B, rA=4), valE=64'h400, valM=64'hABCD, commit** → `R4`=64'hABCD.
- **cmovXX (icode 2), rA=1, rB=3**:
  - `cnd`=0 → `dstE`=F and `R3` unchanged.
  - `cnd`=1 → `R3`=`valE`.
- **halt (icode 0), commit** → `stat`=2, `halted`=1. A subsequent OPq with `commit` writes nothing and `stat` stays 2.
- **Errors and reset**:
  - `imem_error`=1 together with `instr_valid`=0 → `stat`=3 (ADR takes priority), no write.
  - Then `rst`=1 at the same edge as a valid commit → `stat`=1 and registers are at reset values.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs and status codes.
package y86_pkg;

   localparam int unsigned WORD_W = 64;
   localparam int unsigned NREGS  = 15;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] REG_RSP  = 4'h4;
   localparam logic [3:0] REG_NONE = 4'hF;

   typedef enum logic [2:0] {
      S_AOK = 3'd1,
      S_HLT = 3'd2,
      S_ADR = 3'd3,
      S_INS = 3'd4
   } stat_e;

endpackage

// File: rtl/regfile_15x64.sv
// 15x64 register file: two read ports plus debug read, E and M write ports (M wins).
module regfile_15x64
   import y86_pkg::*;
#(
   parameter logic [63:0] RSP_INIT = 64'h3F8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  raddr_a_i,
   output logic [63:0] rdata_a_o,
   input  logic [3:0]  raddr_b_i,
   output logic [63:0] rdata_b_o,
   input  logic [3:0]  dbg_addr_i,
   output logic [63:0] dbg_data_o,
   input  logic        we_e_i,
   input  logic [3:0]  waddr_e_i,
   input  logic [63:0] wdata_e_i,
   input  logic        we_m_i,
   input  logic [3:0]  waddr_m_i,
   input  logic [63:0] wdata_m_i
);

   logic [WORD_W-1:0] regs_q [NREGS];
   logic [WORD_W-1:0] regs_d [NREGS];

   // Next array contents; M port is applied after E so it wins on a shared address.
   always_comb begin
      for (int i = 0; i < int'(NREGS); i++) begin
         regs_d[i] = regs_q[i];
         if (we_e_i && (waddr_e_i == 4'(i))) begin
            regs_d[i] = wdata_e_i;
         end
         if (we_m_i && (waddr_m_i == 4'(i))) begin
            regs_d[i] = wdata_m_i;
         end
      end
   end

   // Array storage with synchronous reset; %rsp starts at RSP_INIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs_q[i] <= (4'(i) == REG_RSP) ? RSP_INIT : '0;
         end
      end else begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Combinational reads; address F matches no entry and returns zero.
   always_comb begin
      rdata_a_o  = '0;
      rdata_b_o  = '0;
      dbg_data_o = '0;
      for (int i = 0; i < int'(NREGS); i++) begin
         if (raddr_a_i == 4'(i)) begin
            rdata_a_o = regs_q[i];
         end
         if (raddr_b_i == 4'(i)) begin
            rdata_b_o = regs_q[i];
         end
         if (dbg_addr_i == 4'(i)) begin
            dbg_data_o = regs_q[i];
         end
      end
   end

endmodule

// File: rtl/decode_writeback.sv
// SEQ Y86-64 decode and write-back stage with the processor status state machine.
module decode_writeback
   import y86_pkg::*;
#(
   parameter logic [63:0] RSP_INIT = 64'h3F8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  icode,
   input  logic [3:0]  ifun,
   input  logic [3:0]  rA,
   input  logic [3:0]  rB,
   input  logic        instr_valid,
   input  logic        imem_error,
   input  logic        dmem_error,
   input  logic        cnd,
   input  logic [63:0] valE,
   input  logic [63:0] valM,
   input  logic        commit,
   output logic [3:0]  srcA,
   output logic [3:0]  srcB,
   output logic [3:0]  dstE,
   output logic [3:0]  dstM,
   output logic [63:0] valA,
   output logic [63:0] valB,
   output logic [2:0]  stat,
   output logic        halted,
   input  logic [3:0]  dbg_addr,
   output logic [63:0] dbg_data
);

   stat_e stat_q;
   stat_e stat_nxt_c;
   logic  wb_en_c;

   // ifun legality is already folded into instr_valid upstream.
   logic  unused_ifun;
   assign unused_ifun = ^ifun;

   // Register-ID decode from icode and the instruction's register specifiers.
   always_comb begin
      srcA = REG_NONE;
      srcB = REG_NONE;
      dstE = REG_NONE;
      dstM = REG_NONE;
      case (icode)
         I_RRMOVQ: begin
            srcA = rA;
            dstE = cnd ? rB : REG_NONE;
         end
         I_IRMOVQ: begin
            dstE = rB;
         end
         I_RMMOVQ: begin
            srcA = rA;
            srcB = rB;
         end
         I_MRMOVQ: begin
            srcB = rB;
            dstM = rA;
         end
         I_OPQ: begin
            srcA = rA;
            srcB = rB;
            dstE = rB;
         end
         I_CALL: begin
            srcB = REG_RSP;
            dstE = REG_RSP;
         end
         I_RET: begin
            srcA = REG_RSP;
            srcB = REG_RSP;
            dstE = REG_RSP;
         end
         I_PUSHQ: begin
            srcA = rA;
            srcB = REG_RSP;
            dstE = REG_RSP;
         end
         I_POPQ: begin
            srcA = REG_RSP;
            srcB = REG_RSP;
            dstE = REG_RSP;
            dstM = rA;
         end
         default: begin
         end
      endcase
   end

   // Status this instruction would produce; address errors outrank illegal ops outrank halt.
   always_comb begin
      stat_nxt_c = S_AOK;
      if (imem_error || dmem_error) begin
         stat_nxt_c = S_ADR;
      end else if (!instr_valid) begin
         stat_nxt_c = S_INS;
      end else if (icode == I_HALT) begin
         stat_nxt_c = S_HLT;
      end
   end

   // Only a committed instruction that leaves the machine in AOK may write registers.
   assign wb_en_c = commit && (stat_q == S_AOK) && (stat_nxt_c == S_AOK);

   // Status FSM: leaves AOK only on a commit; HLT/ADR/INS hold until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_q <= S_AOK;
      end else if (commit) begin
         case (stat_q)
            S_AOK:   stat_q <= stat_nxt_c;
            S_HLT:   stat_q <= S_HLT;
            S_ADR:   stat_q <= S_ADR;
            S_INS:   stat_q <= S_INS;
            default: stat_q <= S_INS;
         endcase
      end
   end

   assign stat   = stat_q;
   assign halted = (stat_q != S_AOK);

   regfile_15x64 #(
      .RSP_INIT (RSP_INIT)
   ) u_regfile (
      .clk        (clk),
      .rst        (rst),
      .raddr_a_i  (srcA),
      .rdata_a_o  (valA),
      .raddr_b_i  (srcB),
      .rdata_b_o  (valB),
      .dbg_addr_i (dbg_addr),
      .dbg_data_o (dbg_data),
      .we_e_i     (wb_en_c),
      .waddr_e_i  (dstE),
      .wdata_e_i  (valE),
      .we_m_i     (wb_en_c),
      .waddr_m_i  (dstM),
      .wdata_m_i  (valM)
   );

endmodule

// File: tb/tb_decode_writeback.sv
// Randomized scoreboard bench for decode_writeback against an array-based reference model.
module tb_decode_writeback;

   localparam logic [63:0] RSP_INIT = 64'h3F8;

   typedef struct {
      logic        rst;
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic        valid;
      logic        imem;
      logic        dmem;
      logic        cnd;
      logic [63:0] vale;
      logic [63:0] valm;
      logic        commit;
      logic [3:0]  dbg;
   } stim_t;

   typedef struct {
      logic [3:0]  srca;
      logic [3:0]  srcb;
      logic [3:0]  dste;
      logic [3:0]  dstm;
      logic [63:0] vala;
      logic [63:0] valb;
      logic [63:0] dbg;
      logic [2:0]  stat;
      logic        halted;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  icode, ifun, rA, rB, dbg_addr;
   logic        instr_valid, imem_error, dmem_error, cnd, commit;
   logic [63:0] valE, valM;
   logic [3:0]  srcA, srcB, dstE, dstM;
   logic [63:0] valA, valB, dbg_data;
   logic [2:0]  stat;
   logic        halted;

   int nchecks = 0;
   int nerrs   = 0;

   // Reference state: plain array of register values plus status number.
   logic [63:0] m_reg [15];
   int          m_stat;

   exp_t  exp_q[$];
   stim_t cur;

   always #5 clk = ~clk;

   decode_writeback #(.RSP_INIT(RSP_INIT)) dut (
      .clk(clk), .rst(rst), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
      .instr_valid(instr_valid), .imem_error(imem_error), .dmem_error(dmem_error),
      .cnd(cnd), .valE(valE), .valM(valM), .commit(commit),
      .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
      .valA(valA), .valB(valB), .stat(stat), .halted(halted),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   function automatic logic [3:0] f_srca(input stim_t s);
      if (s.icode inside {4'h2, 4'h4, 4'h6, 4'hA}) return s.ra;
      if (s.icode inside {4'h9, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] f_srcb(input stim_t s);
      if (s.icode inside {4'h4, 4'h5, 4'h6}) return s.rb;
      if (s.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] f_dste(input stim_t s);
      if (s.icode == 4'h2) return s.cnd ? s.rb : 4'hF;
      if (s.icode inside {4'h3, 4'h6}) return s.rb;
      if (s.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] f_dstm(input stim_t s);
      if (s.icode inside {4'h5, 4'hB}) return s.ra;
      return 4'hF;
   endfunction

   function automatic logic [63:0] f_rd(input logic [3:0] a);
      if (a == 4'hF) return 64'd0;
      return m_reg[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 15; i++) m_reg[i] = (i == 4) ? RSP_INIT : 64'd0;
      m_stat = 1;
   endtask

   // Apply the effect of a clock edge with stimulus s to the reference model.
   task automatic model_edge(input stim_t s);
      int nxt;
      logic [3:0] de, dm;
      if (s.rst) begin
         model_reset();
      end else if (s.commit && m_stat == 1) begin
         if (s.imem || s.dmem)    nxt = 3;
         else if (!s.valid)       nxt = 4;
         else if (s.icode == 4'h0) nxt = 2;
         else                     nxt = 1;
         if (nxt == 1) begin
            de = f_dste(s);
            dm = f_dstm(s);
            if (de != 4'hF) m_reg[de] = s.vale;
            if (dm != 4'hF) m_reg[dm] = s.valm;
         end
         m_stat = nxt;
      end
   endtask

   task automatic drive(input stim_t s);
      rst = s.rst; icode = s.icode; ifun = s.ifun; rA = s.ra; rB = s.rb;
      instr_valid = s.valid; imem_error = s.imem; dmem_error = s.dmem;
      cnd = s.cnd; valE = s.vale; valM = s.valm; commit = s.commit;
      dbg_addr = s.dbg;
   endtask

   function automatic exp_t predict(input stim_t s);
      exp_t e;
      e.srca   = f_srca(s);
      e.srcb   = f_srcb(s);
      e.dste   = f_dste(s);
      e.dstm   = f_dstm(s);
      e.vala   = f_rd(e.srca);
      e.valb   = f_rd(e.srcb);
      e.dbg    = f_rd(s.dbg);
      e.stat   = 3'(m_stat);
      e.halted = (m_stat != 1);
      return e;
   endfunction

   function automatic stim_t mk(input logic r, input logic [3:0] ic, input logic [3:0] ra,
                                input logic [3:0] rb, input logic v, input logic im,
                                input logic c, input logic [63:0] ve, input logic [63:0] vm,
                                input logic cm, input logic [3:0] d);
      stim_t s;
      s.rst = r; s.icode = ic; s.ifun = 4'h0; s.ra = ra; s.rb = rb; s.valid = v;
      s.imem = im; s.dmem = 1'b0; s.cnd = c; s.vale = ve; s.valm = vm;
      s.commit = cm; s.dbg = d;
      return s;
   endfunction

   function automatic stim_t idle(input logic [3:0] d);
      return mk(1'b0, 4'h1, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, d);
   endfunction

   function automatic stim_t rnd(input logic halted_now);
      stim_t s;
      int r;
      s.rst    = ($urandom_range(0, 99) < 2) || (halted_now && $urandom_range(0, 99) < 30);
      r        = int'($urandom_range(0, 99));
      if (r < 3)      s.icode = 4'h0;
      else if (r < 7) s.icode = 4'($urandom_range(12, 15));
      else            s.icode = 4'($urandom_range(1, 11));
      s.ifun   = 4'($urandom_range(0, 15));
      s.ra     = 4'($urandom_range(0, 15));
      s.rb     = 4'($urandom_range(0, 15));
      s.valid  = ($urandom_range(0, 99) >= 4);
      s.imem   = ($urandom_range(0, 99) < 2);
      s.dmem   = ($urandom_range(0, 99) < 2);
      s.cnd    = 1'($urandom_range(0, 1));
      s.vale   = {$urandom, $urandom};
      s.valm   = {$urandom, $urandom};
      s.commit = ($urandom_range(0, 99) < 70);
      s.dbg    = 4'($urandom_range(0, 15));
      return s;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      nchecks++;
      if (act !== expv) begin
         nerrs++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
      end
   endtask

   // Monitor: DUT outputs are valid every cycle; compare at the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("srcA",     64'(srcA),     64'(e.srca));
         chk("srcB",     64'(srcB),     64'(e.srcb));
         chk("dstE",     64'(dstE),     64'(e.dste));
         chk("dstM",     64'(dstM),     64'(e.dstm));
         chk("valA",     valA,          e.vala);
         chk("valB",     valB,          e.valb);
         chk("dbg_data", dbg_data,      e.dbg);
         chk("stat",     64'(stat),     64'(e.stat));
         chk("halted",   64'(halted),   64'(e.halted));
      end
   end

   stim_t dir_q[$];

   initial begin
      model_reset();
      // Directed sequence following the reset / irmovq / popq / cmov / halt / error scenarios.
      dir_q.push_back(idle(4'h4));
      dir_q.push_back(idle(4'h0));
      dir_q.push_back(mk(1'b0, 4'h3, 4'hF, 4'h2, 1'b1, 1'b0, 1'b0, 64'h1234, 64'd0, 1'b1, 4'h2));
      dir_q.push_back(idle(4'h2));
      dir_q.push_back(mk(1'b0, 4'hB, 4'h4, 4'hF, 1'b1, 1'b0, 1'b0, 64'h400, 64'hABCD, 1'b1, 4'h4));
      dir_q.push_back(idle(4'h4));
      dir_q.push_back(mk(1'b0, 4'h2, 4'h1, 4'h3, 1'b1, 1'b0, 1'b0, 64'h55, 64'd0, 1'b1, 4'h3));
      dir_q.push_back(idle(4'h3));
      dir_q.push_back(mk(1'b0, 4'h2, 4'h1, 4'h3, 1'b1, 1'b0, 1'b1, 64'h77, 64'd0, 1'b1, 4'h3));
      dir_q.push_back(idle(4'h3));
      dir_q.push_back(mk(1'b0, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 4'h3));
      dir_q.push_back(mk(1'b0, 4'h6, 4'h1, 4'h3, 1'b1, 1'b0, 1'b0, 64'h99, 64'd0, 1'b1, 4'h3));
      dir_q.push_back(idle(4'h3));
      dir_q.push_back(mk(1'b1, 4'h1, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 4'h3));
      dir_q.push_back(mk(1'b0, 4'h6, 4'h1, 4'h2, 1'b0, 1'b1, 1'b0, 64'h66, 64'd0, 1'b1, 4'h2));
      dir_q.push_back(idle(4'h2));
      dir_q.push_back(mk(1'b1, 4'h3, 4'hF, 4'h5, 1'b1, 1'b0, 1'b0, 64'h1, 64'd0, 1'b1, 4'h5));
      dir_q.push_back(idle(4'h4));
      dir_q.push_back(idle(4'h5));

      cur = mk(1'b1, 4'h1, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 4'h0);
      drive(cur);

      foreach (dir_q[k]) begin
         @(posedge clk);
         model_edge(cur);
         #1;
         cur = dir_q[k];
         drive(cur);
         exp_q.push_back(predict(cur));
      end

      for (int n = 0; n < 600; n++) begin
         @(posedge clk);
         model_edge(cur);
         #1;
         cur = rnd(m_stat != 1);
         drive(cur);
         exp_q.push_back(predict(cur));
      end

      @(posedge clk);
      model_edge(cur);
      #1;
      drive(idle(4'h0));
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
      $finish;
   end

endmodule
